// File: rtl/switch_bounce_gen_pkg.sv
// Shared types and LFSR definition for the switch bounce emulator and
// the other board self-test stimulus blocks.
package bounce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        BOUNCE,
        SETTLE,
        DONE
    } bounce_state_t;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One Galois shift: right shift, fold the taps in when the bit shifted out was 1.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage

// File: rtl/switch_bounce_gen_if.sv
// Command/status bundle of the switch bounce emulator; the master side
// issues bursts, the slave side is the emulator itself.
interface switch_bounce_gen_if;

    logic start_i;
    logic target_i;
    logic bounced_o;
    logic busy_o;
    logic done_o;

    modport master (
        output start_i,
        output target_i,
        input  bounced_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  target_i,
        output bounced_o,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/switch_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that advances one shift per cycle with step_i high
// and reloads its seed on reset.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        step_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = lfsr_advance(lfsr_q);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical-switch bounce emulator: drives ~target, then a reproducible
// pseudo-random bounce burst, then target for a settle period.
module switch_bounce_gen
    import bounce_pkg::*;
#(
    parameter int unsigned N_BOUNCES     = 20,
    parameter int unsigned BOUNCE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 20,
    parameter logic        IDLE_LEVEL    = 1'b1,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
    input  logic                sysclk,
    input  logic                reset,
    switch_bounce_gen_if.slave  bus
);

    localparam int unsigned MAX_CYCLES  = (BOUNCE_CYCLES > SETTLE_CYCLES) ? BOUNCE_CYCLES
                                                                          : SETTLE_CYCLES;
    localparam int unsigned CNT_W       = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       STEP_LOAD   = 8'(N_BOUNCES);

    bounce_state_t    state_d, state_q;
    logic             tgt_d, tgt_q;
    logic [7:0]       step_d, step_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             bounced_d, bounced_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic             lfsr_step;
    logic [15:0]      lfsr_q;
    logic             lfsr_next_bit;

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .sysclk (sysclk),
        .reset  (reset),
        .step_i (lfsr_step),
        .q_o    (lfsr_q)
    );

    // Bit 0 of the state the LFSR moves to on this edge, so a new step
    // shows its bounce value in the same cycle the LFSR advances.
    assign lfsr_next_bit = ^(lfsr_advance(lfsr_q) & 16'h0001);

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        bounced_d = bounced_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lfsr_step = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d   = PRE;
                    tgt_d     = bus.target_i;
                    bounced_d = ~bus.target_i;
                    busy_d    = 1'b1;
                    cnt_d     = BOUNCE_LOAD;
                    step_d    = STEP_LOAD;
                end
            end

            // PRE and BOUNCE end the same way: start another step while
            // steps remain (step_q still holds N_BOUNCES in PRE), else settle.
            PRE, BOUNCE: begin
                if (cnt_q == CNT_ONE) begin
                    if (step_q != 8'd0) begin
                        state_d   = BOUNCE;
                        lfsr_step = 1'b1;
                        bounced_d = lfsr_next_bit;
                        cnt_d     = BOUNCE_LOAD;
                        step_d    = step_q - 8'd1;
                    end else begin
                        state_d   = SETTLE;
                        bounced_d = tgt_q;
                        cnt_d     = SETTLE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            SETTLE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            step_q    <= '0;
            cnt_q     <= '0;
            bounced_q <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            bounced_q <= bounced_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.bounced_o = bounced_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: reset, nominal bursts against an
// LFSR reference, zero-bounce config, held start, mid-burst reset.
module tb_switch_bounce_gen;
    import bounce_pkg::*;

    localparam int N0 = 4;
    localparam int B0 = 2;
    localparam int S0 = 8;
    localparam int N1 = 0;
    localparam int B1 = 3;
    localparam int S1 = 5;

    logic sysclk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] model;

    always #5 sysclk = ~sysclk;

    switch_bounce_gen_if bus0 ();
    switch_bounce_gen_if bus1 ();

    switch_bounce_gen #(
        .N_BOUNCES     (N0),
        .BOUNCE_CYCLES (B0),
        .SETTLE_CYCLES (S0)
    ) dut0 (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus0)
    );

    switch_bounce_gen #(
        .N_BOUNCES     (N1),
        .BOUNCE_CYCLES (B1),
        .SETTLE_CYCLES (S1)
    ) dut1 (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic tick(input bit toggle);
        if (toggle) bus0.target_i = ~bus0.target_i;
        @(negedge sysclk);
    endtask

    // Called at the negedge right after the accepting edge; returns at the
    // negedge of the IDLE cycle that follows DONE.
    task automatic check_burst0(input logic tgt, input bit toggle);
        logic nt;
        logic bit_exp;
        int   busy_cnt;
        int   done_cnt;
        nt       = ~tgt;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < B0; i++) begin
            check("pre_level", bus0.bounced_o, nt);
            busy_cnt += int'(bus0.busy_o);
            done_cnt += int'(bus0.done_o);
            tick(toggle);
        end
        for (int s = 0; s < N0; s++) begin
            model   = ref_step(model);
            bit_exp = model[0];
            for (int j = 0; j < B0; j++) begin
                check("bounce_level", bus0.bounced_o, bit_exp);
                busy_cnt += int'(bus0.busy_o);
                done_cnt += int'(bus0.done_o);
                tick(toggle);
            end
        end
        for (int i = 0; i < S0; i++) begin
            check("settle_level", bus0.bounced_o, tgt);
            busy_cnt += int'(bus0.busy_o);
            done_cnt += int'(bus0.done_o);
            tick(toggle);
        end
        check("busy_length", 16'(busy_cnt), 16'((1 + N0) * B0 + S0));
        check("early_done", 16'(done_cnt), 16'd0);
        check("done_pulse", bus0.done_o, 1'b1);
        check("done_busy", bus0.busy_o, 1'b0);
        check("done_level", bus0.bounced_o, tgt);
        tick(toggle);
        check("idle_done", bus0.done_o, 1'b0);
        check("idle_busy", bus0.busy_o, 1'b0);
        check("idle_level", bus0.bounced_o, tgt);
    endtask

    initial begin
        logic t;

        // Reset held with start high: outputs must stay at reset values.
        reset         = 1'b1;
        bus0.start_i  = 1'b1;
        bus0.target_i = 1'b0;
        bus1.start_i  = 1'b0;
        bus1.target_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            check("rst_bounced", bus0.bounced_o, 1'b1);
            check("rst_busy", bus0.busy_o, 1'b0);
            check("rst_done", bus0.done_o, 1'b0);
            check("rst_bounced1", bus1.bounced_o, 1'b1);
        end

        // Release with start still high: accepted on the very next edge.
        reset = 1'b0;
        @(negedge sysclk);
        bus0.start_i = 1'b0;
        check("first_busy", bus0.busy_o, 1'b1);
        model = 16'hACE1;
        check_burst0(1'b0, 1'b0);

        // Zero-bounce configuration: ~target, then target, LFSR untouched.
        bus1.start_i  = 1'b1;
        bus1.target_i = 1'b1;
        @(negedge sysclk);
        bus1.start_i = 1'b0;
        for (int i = 0; i < B1; i++) begin
            check("n0_pre_level", bus1.bounced_o, 1'b0);
            check("n0_pre_busy", bus1.busy_o, 1'b1);
            @(negedge sysclk);
        end
        for (int i = 0; i < S1; i++) begin
            check("n0_settle_level", bus1.bounced_o, 1'b1);
            check("n0_settle_busy", bus1.busy_o, 1'b1);
            @(negedge sysclk);
        end
        check("n0_done", bus1.done_o, 1'b1);
        check("n0_lfsr", dut1.u_lfsr.q_o, 16'hACE1);
        @(negedge sysclk);
        check("n0_idle_done", bus1.done_o, 1'b0);
        check("n0_idle_level", bus1.bounced_o, 1'b1);

        // Start held high, target toggling: one burst each, LFSR continues.
        bus0.start_i  = 1'b1;
        bus0.target_i = 1'b1;
        @(negedge sysclk);
        check_burst0(1'b1, 1'b1);
        bus0.target_i = 1'b0;
        @(negedge sysclk);
        check_burst0(1'b0, 1'b1);
        bus0.start_i = 1'b0;

        // Reset mid-BOUNCE: immediate reset values, then a fresh sequence.
        bus0.target_i = 1'b0;
        bus0.start_i  = 1'b1;
        @(negedge sysclk);
        bus0.start_i = 1'b0;
        for (int i = 0; i < B0 + 3; i++) @(negedge sysclk);
        #2 reset = 1'b1;
        #1;
        check("async_bounced", bus0.bounced_o, 1'b1);
        check("async_busy", bus0.busy_o, 1'b0);
        check("async_done", bus0.done_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge sysclk);
            check("rst_hold_done", bus0.done_o, 1'b0);
            check("rst_hold_busy", bus0.busy_o, 1'b0);
        end
        reset        = 1'b0;
        bus0.start_i = 1'b1;
        @(negedge sysclk);
        bus0.start_i = 1'b0;
        model = 16'hACE1;
        check_burst0(1'b0, 1'b0);

        // Random-target bursts continuing the LFSR sequence.
        for (int b = 0; b < 6; b++) begin
            t             = 1'($urandom_range(0, 1));
            bus0.start_i  = 1'b1;
            bus0.target_i = t;
            @(negedge sysclk);
            bus0.start_i = 1'b0;
            check_burst0(t, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
